blink_rate_detector: RTL and testbench

Receive-side counterpart to the board's LED blink generators. The block samples one asynchronous square-wave input, such as a looped-back LED drive or a PMOD pin. It measures the interval between successive transitions and classifies the blink rate as 1, 2, 5 or 10 Hz. It reports the rate only after a run of consistent measurements, and drops it on mismatch or loss of signal.

---
 rtl/blink_rate_detector.sv | 146 ++++++++++++++
 tb/tb_blink_rate_detector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_detector.sv
// Blink-rate detector: measures the interval between i_Sig transitions,
// classifies it as 1/2/5/10 Hz and locks after LOCK_COUNT consistent intervals.
module blink_rate_detector #(
  parameter int CNT_W      = 25,
  parameter int HP_1       = 12500000,
  parameter int HP_2       = 6250000,
  parameter int HP_5       = 2500000,
  parameter int HP_10      = 1250000,
  parameter int TOL_SHIFT  = 4,
  parameter int TIMEOUT    = 25000000,
  parameter int LOCK_COUNT = 3
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Sig,
  output logic [2:0]       o_Rate,
  output logic             o_Valid,
  output logic [CNT_W-1:0] o_Period,
  output logic             o_Period_Strobe
);

  localparam int MW = $clog2(LOCK_COUNT + 1) + 1;
  localparam logic [CNT_W-1:0] L_HP1     = CNT_W'(HP_1);
  localparam logic [CNT_W-1:0] L_HP2     = CNT_W'(HP_2);
  localparam logic [CNT_W-1:0] L_HP5     = CNT_W'(HP_5);
  localparam logic [CNT_W-1:0] L_HP10    = CNT_W'(HP_10);
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    L_LOCK    = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRACK, S_LOCKED} state_t;

  logic             r_sync1, r_sync2, r_sig_d;
  logic [CNT_W-1:0] r_count;
  state_t           r_state, w_state_next;
  logic [2:0]       r_cand, w_cand_next;
  logic [MW-1:0]    r_match, w_match_next;
  logic [2:0]       r_rate, w_rate_next;
  logic             r_valid, w_valid_next;
  logic [CNT_W-1:0] r_period, w_period_next;
  logic             r_strobe, w_strobe_next;
  logic             w_edge;
  logic [2:0]       w_class;

  // Difference kept at CNT_W+1 bits so it can never wrap.
  function automatic logic is_match(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] hp);
    logic [CNT_W:0] diff;
    if (p >= hp) diff = {1'b0, p} - {1'b0, hp};
    else         diff = {1'b0, hp} - {1'b0, p};
    return diff <= ({1'b0, hp} >> TOL_SHIFT);
  endfunction

  assign w_edge = r_sync2 ^ r_sig_d;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sig_d <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync1 <= i_Sig;
      r_sync2 <= r_sync1;
      r_sig_d <= r_sync2;
      if (w_edge)                   r_count <= CNT_W'(1);
      else if (r_count < L_TIMEOUT) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_class = 3'd0;
    if      (is_match(r_count, L_HP1))  w_class = 3'd1;
    else if (is_match(r_count, L_HP2))  w_class = 3'd2;
    else if (is_match(r_count, L_HP5))  w_class = 3'd3;
    else if (is_match(r_count, L_HP10)) w_class = 3'd4;
  end

  always_comb begin
    w_state_next  = r_state;
    w_cand_next   = r_cand;
    w_match_next  = r_match;
    w_rate_next   = r_rate;
    w_valid_next  = r_valid;
    w_period_next = r_period;
    w_strobe_next = 1'b0;
    if (w_edge) begin
      if (r_state == S_IDLE) begin
        w_state_next = S_ARMED;
      end else begin
        w_strobe_next = 1'b1;
        w_period_next = r_count;
        if (!(r_state == S_LOCKED && w_class == r_rate)) begin
          // Leaving lock: drop the rate, then re-run this interval through TRACK/ARMED.
          w_rate_next  = 3'd0;
          w_valid_next = 1'b0;
          if (w_class == 3'd0) begin
            w_state_next = S_ARMED;
          end else begin
            if (r_state == S_TRACK && w_class == r_cand) begin
              w_match_next = r_match + 1'b1;
            end else begin
              w_cand_next  = w_class;
              w_match_next = MW'(1);
            end
            if (w_match_next >= L_LOCK) begin
              w_state_next = S_LOCKED;
              w_rate_next  = w_cand_next;
              w_valid_next = 1'b1;
            end else begin
              w_state_next = S_TRACK;
            end
          end
        end
      end
    end else if (r_state != S_IDLE && r_count == L_TIMEOUT) begin
      w_state_next = S_IDLE;
      w_rate_next  = 3'd0;
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state  <= S_IDLE;
      r_cand   <= 3'd0;
      r_match  <= '0;
      r_rate   <= 3'd0;
      r_valid  <= 1'b0;
      r_period <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cand   <= w_cand_next;
      r_match  <= w_match_next;
      r_rate   <= w_rate_next;
      r_valid  <= w_valid_next;
      r_period <= w_period_next;
      r_strobe <= w_strobe_next;
    end
  end

  assign o_Rate          = r_rate;
  assign o_Valid         = r_valid;
  assign o_Period        = r_period;
  assign o_Period_Strobe = r_strobe;

endmodule

// File: tb/tb_blink_rate_detector.sv
// Scoreboard bench: each driven transition pushes the expected strobe; a
// negedge monitor pops and compares. Reference model works on interval runs.
module tb_blink_rate_detector;

  localparam int CNT_W   = 25;
  localparam int TIMEOUT = 2000;
  localparam int LOCK_N  = 3;

  logic             clk, rst, sig;
  logic [2:0]       rate;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic             strobe;

  blink_rate_detector #(
    .CNT_W(CNT_W), .HP_1(1000), .HP_2(500), .HP_5(200), .HP_10(100),
    .TOL_SHIFT(4), .TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_N)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Sig(sig),
    .o_Rate(rate), .o_Valid(valid), .o_Period(period), .o_Period_Strobe(strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int period;
    int rate;
    bit valid;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_strobe_cyc = 0;
  int   last_toggle_cyc = 0;

  // Reference model: armed flag plus the run of equal nonzero classes.
  bit   m_armed = 1'b0;
  int   m_run_cls = 0;
  int   m_run_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int classify(int p);
    int hp[4] = '{1000, 500, 200, 100};
    for (int i = 0; i < 4; i++) begin
      int d = p - hp[i];
      if (d < 0) d = -d;
      if (d <= hp[i] / 16) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_edge(int gap);
    exp_t e;
    int   c;
    if (!m_armed || gap > TIMEOUT) begin
      m_armed   = 1'b1;
      m_run_cls = 0;
      m_run_len = 0;
    end else begin
      c = classify(gap);
      if (c == 0) begin
        m_run_len = 0;
        m_run_cls = 0;
      end else if (c == m_run_cls) begin
        m_run_len++;
      end else begin
        m_run_cls = c;
        m_run_len = 1;
      end
      e.period = gap;
      e.valid  = (c != 0) && (m_run_len >= LOCK_N);
      e.rate   = e.valid ? c : 0;
      q.push_back(e);
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && strobe) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got strobe with period %0d, expected none (cycle %0d)", period, cyc);
      end else begin
        mon_e = q.pop_front();
        check("period", int'(period), mon_e.period);
        check("rate", int'(rate), mon_e.rate);
        check("valid", int'(valid), int'(mon_e.valid));
        $display("strobe cycle %0d: period %0d rate %0d valid %0d", cyc, period, rate, valid);
      end
      last_strobe_cyc = cyc;
    end
  end

  task automatic toggle(int n);
    repeat (n) @(posedge clk);
    #1 sig = ~sig;
    model_edge(cyc - last_toggle_cyc);
    last_toggle_cyc = cyc;
  endtask

  task automatic toggles(int n, int count);
    for (int i = 0; i < count; i++) toggle(n);
  endtask

  task automatic do_reset(bit sig_at_release);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_rate", int'(rate), 0);
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_period", int'(period), 0);
    check("async_rst_strobe", int'(strobe), 0);
    sig = sig_at_release;
    q.delete();
    m_armed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    last_toggle_cyc = cyc;
    if (sig_at_release) model_edge(0);
  endtask

  initial begin
    int  delta;
    bit  seen;
    rst = 1'b1;
    sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rate", int'(rate), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_period", int'(period), 0);
    check("reset_strobe", int'(strobe), 0);
    rst = 1'b0;
    last_toggle_cyc = cyc;

    // Lock at 2 Hz
    toggle(10);
    toggles(500, 5);
    // Tolerance boundary: 106 matches 10 Hz, 107 matches nothing
    toggle(106);
    toggle(107);
    toggles(100, 4);
    // Rate change while locked
    toggles(1000, 4);
    toggles(200, 4);

    // Timeout after locking at 5 Hz
    repeat (10) @(posedge clk);
    #1;
    check("locked_before_timeout", int'(valid), 1);
    seen = 1'b0;
    for (int i = 0; i < 2300 && !seen; i++) begin
      @(negedge clk);
      if (!valid) seen = 1'b1;
    end
    check("timeout_seen", int'(seen), 1);
    delta = cyc - last_strobe_cyc;
    n_cmp++;
    if (delta < TIMEOUT - 1 || delta > TIMEOUT + 1) begin
      n_bad++;
      $display("FAIL timeout_delay: got %0d clocks, expected %0d +/- 1", delta, TIMEOUT);
    end
    check("timeout_rate", int'(rate), 0);
    $display("timeout after %0d clocks", delta);
    toggle(100);
    toggles(200, 3);

    // Reset mid-interval while locked, released with i_Sig low then high
    toggle(100);
    check("locked_before_reset", int'(valid), 1);
    do_reset(1'b0);
    toggle(50);
    toggles(200, 3);
    repeat (20) @(posedge clk);
    #1;
    check("relock_after_reset", int'(valid), 1);
    do_reset(1'b1);
    toggles(200, 3);

    // Jitter around 10 Hz
    for (int i = 0; i < 4; i++) begin
      toggle(95);
      toggle(105);
    end

    // Randomized segments of near-nominal intervals
    for (int s = 0; s < 5; s++) begin
      int hp;
      int tol;
      int len;
      case ($urandom_range(0, 3))
        0:       hp = 1000;
        1:       hp = 500;
        2:       hp = 200;
        default: hp = 100;
      endcase
      tol = hp / 16;
      len = $urandom_range(3, 6);
      for (int k = 0; k < len; k++)
        toggle(hp - tol - 2 + int'($urandom_range(0, 2 * tol + 4)));
    end

    repeat (20) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
